color_detect_udiv_32ns_16ns_seq: RTL and testbench

COLOR_DETECT_UDIV_32NS_16NS_SEQ -- requirements
Module: color_detect_udiv_32ns_16ns_seq

---
 rtl/color_detect_udiv_32ns_16ns_seq_pkg.sv | 18 +
 rtl/color_detect_udiv_32ns_16ns_seq.sv | 150 +++++++++++++++
 tb/tb_color_detect_udiv_32ns_16ns_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/color_detect_udiv_32ns_16ns_seq_pkg.sv
// Shared accelerator package: divider FSM encoding and constants.
//   div_state_e   : IDLE / BUSY / DONE state encoding
//   ITER_COUNT    : quotient bits produced, one per enabled cycle
//   CNT_W         : iteration counter width
//   DIV_ZERO_QUOT : quotient reported for a zero divisor
package color_detect_udiv_32ns_16ns_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int          ITER_COUNT    = 32;
  localparam int          CNT_W         = $clog2(ITER_COUNT);
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/color_detect_udiv_32ns_16ns_seq.sv
// Iterative restoring divider, 32-bit dividend / 16-bit divisor, unsigned.
// One quotient bit per enabled cycle, MSB first; 32 iterations per divide.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   ce       : clock enable, all state holds while low
//   start    : begin a divide (accepted only while ready)
//   din0     : dividend
//   din1     : divisor
//   ready    : high in IDLE
//   done     : high for one enabled cycle when the result is valid
//   quot     : quotient
//   rem      : remainder
//   div_zero : set with done when the divisor was 0
module color_detect_udiv_32ns_16ns_seq
  import color_detect_udiv_32ns_16ns_seq_pkg::*;
#(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = 32,
  parameter int          din1_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero
);

  div_state_e state_q, state_d;

  // Working registers: dvd_q shifts the dividend out of its MSB while the
  // quotient bits shift in at the LSB, so it ends up holding the quotient.
  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [din0_WIDTH-1:0] dvd_q,  dvd_d;
  logic [din1_WIDTH-1:0] dvs_q,  dvs_d;
  logic [din1_WIDTH-1:0] prem_q, prem_d;

  // Visible results live in separate registers so partial values never show.
  logic [din0_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q,  rem_d;
  logic                  dz_q,   dz_d;

  logic                  accept;
  logic                  last_iter;
  logic [din1_WIDTH:0]   partial;
  logic [din1_WIDTH:0]   diff;
  logic                  qbit;
  logic [din1_WIDTH-1:0] prem_nx;
  logic [din0_WIDTH-1:0] dvd_nx;

  assign accept    = ce && start && (state_q == ST_IDLE);
  assign last_iter = (cnt_q == CNT_W'(ITER_COUNT - 1));

  // One restoring step; the remainder after subtraction is always below
  // the divisor, so dropping the 17th bit is lossless.
  always_comb begin
    partial = {prem_q, dvd_q[din0_WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    qbit    = (partial >= {1'b0, dvs_q});
    prem_nx = qbit ? diff[din1_WIDTH-1:0] : partial[din1_WIDTH-1:0];
    dvd_nx  = {dvd_q[din0_WIDTH-2:0], qbit};
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ce) begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = (din1 == '0) ? ST_DONE : ST_BUSY;
        ST_BUSY: if (last_iter) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

  // Datapath next-state
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    if (accept) begin
      cnt_d  = '0;
      dvd_d  = din0;
      dvs_d  = din1;
      prem_d = '0;
      if (din1 == '0) begin
        quot_d = DIV_ZERO_QUOT;
        rem_d  = din0[din1_WIDTH-1:0];
        dz_d   = 1'b1;
      end
    end else if (ce && state_q == ST_BUSY) begin
      cnt_d  = cnt_q + 1'b1;
      dvd_d  = dvd_nx;
      prem_d = prem_nx;
      if (last_iter) begin
        quot_d = dvd_nx;
        rem_d  = prem_nx;
        dz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_color_detect_udiv_32ns_16ns_seq.sv
// Directed bench for the sequential 32/16 divider. Inputs change and outputs
// are sampled on the falling edge; latency is counted in rising edges after
// the accept edge.
module tb_color_detect_udiv_32ns_16ns_seq;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        start;
  logic [31:0] din0;
  logic [15:0] din1;
  logic        ready;
  logic        done;
  logic [31:0] quot;
  logic [15:0] rem;
  logic        div_zero;

  int nvec = 0;
  int nmis = 0;

  color_detect_udiv_32ns_16ns_seq #(
    .ID(32'd1), .din0_WIDTH(32), .din1_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .ready(ready), .done(done),
    .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Wait for ready (bounded), then pulse start for one rising edge.
  // Returns at the falling edge just after the accept edge.
  task automatic do_start(input logic [31:0] a, input logic [15:0] b);
    int k;
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_start", 32'(ready), 32'd1);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count rising edges until done is seen high (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  int  n;
  int  tot;
  bit  saw_done;

  initial begin
    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_quot",  quot,       32'd0);
    chk("rst_rem",   32'(rem),   32'd0);
    chk("rst_dz",    32'(div_zero), 32'd0);
    reset = 1'b1;

    // 100 / 7, started on the first edge after reset release
    do_start(32'd100, 16'd7);
    chk("busy_ready", 32'(ready), 32'd0);
    wait_done(n);
    chk("lat_100_7",  32'(n),     32'd32);
    chk("quot_100_7", quot,       32'd14);
    chk("rem_100_7",  32'(rem),   32'd2);
    chk("dz_100_7",   32'(div_zero), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done),  32'd0);
    chk("hold_quot",  quot,       32'd14);

    // All-ones / 1
    do_start(32'hFFFF_FFFF, 16'd1);
    wait_done(n);
    chk("lat_ff_1",  32'(n),   32'd32);
    chk("quot_ff_1", quot,     32'hFFFF_FFFF);
    chk("rem_ff_1",  32'(rem), 32'd0);

    // Large divisor
    do_start(32'h1234_5678, 16'hFFFF);
    wait_done(n);
    chk("quot_big", quot,     32'h0000_1234);
    chk("rem_big",  32'(rem), 32'h0000_68AC);

    // Divide by zero: done in the cycle right after the accept edge
    do_start(32'd5, 16'd0);
    chk("dz_done",  32'(done),     32'd1);
    chk("dz_quot",  quot,          32'hFFFF_FFFF);
    chk("dz_rem",   32'(rem),      32'd5);
    chk("dz_flag",  32'(div_zero), 32'd1);
    chk("dz_ready", 32'(ready),    32'd0);

    // 100 / 7 with a 10-cycle ce stall and an ignored start mid-BUSY
    do_start(32'd100, 16'd7);
    repeat (5) @(negedge clk);
    ce = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_done",  32'(done),  32'd0);
    chk("stall_ready", 32'(ready), 32'd0);
    ce    = 1'b1;
    start = 1'b1;
    din0  = 32'd1;
    din1  = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    tot = 16 + n;
    chk("lat_stall",  32'(tot),    32'd42);
    chk("quot_stall", quot,        32'd14);
    chk("rem_stall",  32'(rem),    32'd2);
    chk("dz_cleared", 32'(div_zero), 32'd0);
    // done held while frozen in DONE, then drops on the next enabled edge
    ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("frozen_done", 32'(done), 32'd1);
    ce = 1'b1;
    @(negedge clk);
    chk("after_done", 32'(done),  32'd0);
    chk("after_rdy",  32'(ready), 32'd1);

    // Reset in the middle of a divide
    do_start(32'd100, 16'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready),    32'd1);
    chk("mid_rst_done",  32'(done),     32'd0);
    chk("mid_rst_quot",  quot,          32'd0);
    chk("mid_rst_rem",   32'(rem),      32'd0);
    chk("mid_rst_dz",    32'(div_zero), 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_stale_done", 32'(saw_done), 32'd0);

    do_start(32'd9, 16'd3);
    wait_done(n);
    chk("lat_9_3",  32'(n),   32'd32);
    chk("quot_9_3", quot,     32'd3);
    chk("rem_9_3",  32'(rem), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
